// File: rtl/mult_8u_x_8s_pkg.sv
// Shared widths for the 8u x 8s multiplier slice.
package mult_8u_x_8s_pkg;
  localparam int N1_W  = 8;
  localparam int N2_W  = 8;
  localparam int RES_W = 16;
endpackage

// File: rtl/mult_8u_x_8s_if.sv
// Operand/result bundle between the multiplier and its driver.
interface mult_8u_x_8s_if;
  import mult_8u_x_8s_pkg::*;
  logic [N1_W-1:0]  n1;
  logic [N2_W-1:0]  n2;
  logic [RES_W-1:0] result;

  modport master (output n1, output n2, input result);
  modport slave  (input n1, input n2, output result);
endinterface

// File: rtl/mult_8u_x_8s_csa_row.sv
// One 16-bit carry-save row: three vectors in, sum and left-shifted carry out.
module csa_row
  import mult_8u_x_8s_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic [RES_W-1:0] c,
  output logic [RES_W-1:0] sum,
  output logic [RES_W-1:0] carry
);
  assign sum = a ^ b ^ c;
  // Carry out of bit 15 falls off: everything is modulo 2^16.
  assign carry = {(a[RES_W-2:0] & b[RES_W-2:0]) |
                  (a[RES_W-2:0] & c[RES_W-2:0]) |
                  (b[RES_W-2:0] & c[RES_W-2:0]), 1'b0};
endmodule

// File: rtl/mult_8u_x_8s.sv
// Two-stage 8u x 8s multiplier: operand register, then CSA-reduced product register.
module mult_8u_x_8s
  import mult_8u_x_8s_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mult_8u_x_8s_if.slave  bus
);
  localparam int ROWS = N2_W;

  logic [N1_W-1:0]            n1_q;
  logic [N2_W-1:0]            n2_q;
  logic [RES_W-1:0]           result_q;
  logic [ROWS-1:0][RES_W-1:0] pp;
  logic [RES_W-1:0]           s [0:ROWS-2];
  logic [RES_W-1:0]           c [0:ROWS-2];
  logic [RES_W-1:0]           prod;
  logic [RES_W-1:0]           n1_ext;
  logic                       rc;

  always_ff @(posedge clk) begin
    if (reset) begin
      n1_q <= '0;
      n2_q <= '0;
    end else begin
      n1_q <= bus.n1;
      n2_q <= bus.n2;
    end
  end

  assign n1_ext = {{(RES_W-N1_W){1'b0}}, n1_q};

  // Rows 0..6 add n1 weighted by 2^i; row 7 carries weight -2^7, so it is negated.
  always_comb begin
    pp = '0;
    for (int i = 0; i < ROWS-1; i++)
      pp[i] = (n1_ext & {RES_W{n2_q[i]}}) << i;
    pp[ROWS-1] = n2_q[N2_W-1] ? (~(n1_ext << (ROWS-1)) + 1'b1) : '0;
  end

  assign s[0] = pp[0];
  assign c[0] = pp[1];

  for (genvar g = 0; g < ROWS-2; g++) begin : g_csa
    csa_row u_row (
      .a     (s[g]),
      .b     (c[g]),
      .c     (pp[g+2]),
      .sum   (s[g+1]),
      .carry (c[g+1])
    );
  end

  // Final ripple-carry adder merging the carry-save pair.
  always_comb begin
    prod = '0;
    rc   = 1'b0;
    for (int i = 0; i < RES_W; i++) begin
      prod[i] = s[ROWS-2][i] ^ c[ROWS-2][i] ^ rc;
      rc      = (s[ROWS-2][i] & c[ROWS-2][i]) | (s[ROWS-2][i] & rc) | (c[ROWS-2][i] & rc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) result_q <= '0;
    else       result_q <= prod;
  end

  assign bus.result = result_q;
endmodule

// File: tb/tb_mult_8u_x_8s.sv
// Bench: directed vectors, mid-flight reset and a permuted exhaustive sweep vs a signed model.
module tb_mult_8u_x_8s;
  logic clk = 1'b0;
  logic reset;

  mult_8u_x_8s_if bus();

  mult_8u_x_8s dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'($signed(b));
    return p[15:0];
  endfunction

  // Each call is one clock: check the result due now, then present the next operands.
  // A reset cycle discards everything in flight and promises two zero results.
  task automatic cyc(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input bit rst, input logic [15:0] exp);
    exp_t e;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk(e.tag, bus.result, e.exp);
    end
    reset  = rst;
    bus.n1 = a;
    bus.n2 = b;
    if (rst) begin
      q.delete();
      q.push_back('{"rst_edge0", 16'h0000});
      q.push_back('{"rst_edge1", 16'h0000});
    end else begin
      q.push_back('{tag, exp});
    end
  endtask

  initial begin
    int off;
    logic [15:0] idx;
    reset  = 1'b1;
    bus.n1 = '0;
    bus.n2 = '0;

    cyc("rst", 8'h00, 8'h00, 1'b1, 16'h0000);
    cyc("rst", 8'h00, 8'h00, 1'b1, 16'h0000);

    cyc("55x55", 8'h55, 8'h55, 1'b0, 16'h1C39);
    cyc("AAxAA", 8'hAA, 8'hAA, 1'b0, 16'hC6E4);
    cyc("FFx80", 8'hFF, 8'h80, 1'b0, 16'h8080);
    cyc("55xFF", 8'h55, 8'hFF, 1'b0, 16'hFFAB);
    cyc("FFx81", 8'hFF, 8'h81, 1'b0, 16'h817F);
    cyc("FFx7F", 8'hFF, 8'h7F, 1'b0, 16'h7E81);
    cyc("55x81", 8'h55, 8'h81, 1'b0, 16'hD5D5);
    cyc("AAx81", 8'hAA, 8'h81, 1'b0, 16'hABAA);
    cyc("FFx00", 8'hFF, 8'h00, 1'b0, 16'h0000);
    cyc("00xFF", 8'h00, 8'hFF, 1'b0, 16'h0000);
    cyc("00x7F", 8'h00, 8'h7F, 1'b0, 16'h0000);
    cyc("01x01", 8'h01, 8'h01, 1'b0, 16'h0001);

    // Two products in flight, then a one-cycle reset.
    cyc("fl0", 8'hFF, 8'h80, 1'b0, 16'h8080);
    cyc("fl1", 8'hFF, 8'h7F, 1'b0, 16'h7E81);
    cyc("rst_mid", 8'hAA, 8'hAA, 1'b1, 16'h0000);
    cyc("post", 8'h12, 8'hF3, 1'b0, model(8'h12, 8'hF3));

    // Every operand pair once, in a random-offset odd-stride permutation.
    off = int'($urandom_range(0, 65535));
    for (int i = 0; i < 65536; i++) begin
      idx = 16'((i * 40503 + off) & 32'hFFFF);
      cyc("sweep", idx[15:8], idx[7:0], 1'b0, model(idx[15:8], idx[7:0]));
    end

    for (int i = 0; i < 3; i++)
      cyc("drain", 8'h00, 8'h00, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
